square_wave_gen: RTL and testbench

Stimulus source for the 4:1 mux lab stage. Divides the system clock into four phase-aligned square waves at f, 2f, 4f and 8f, and drives the mux select through 00→01→10→11 with a fixed dwell per setting. It sits directly upstream of the mux and feeds its `D[3:0]` and `sel[1:0]` inputs, so the mux can run on hardware without a testbench. It runs either a single pass, ending in DONE, or continuously.

---
 rtl/square_wave_gen_pkg.sv | 18 +
 rtl/square_wave_gen_tick_prescaler.sv | 32 +++
 rtl/square_wave_gen.sv | 106 ++++++++++
 tb/tb_square_wave_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/square_wave_gen_pkg.sv
// Shared types and defaults for the square-wave stimulus generator.
package sqgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sqgen_state_t;

    localparam int unsigned SQGEN_PRESCALE = 3125;
    localparam int unsigned SQGEN_DWELL    = 32;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/square_wave_gen_tick_prescaler.sv
// Divides the system clock down to a one-cycle base-tick strobe while enabled.
module tick_prescaler
    import sqgen_pkg::*;
#(
    parameter int unsigned PRESCALE = SQGEN_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   PW   = cnt_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    assign tick = en && (pcnt == LAST);

    // Held at zero whenever not counting, so a fresh run always starts phase-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clr || !en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/square_wave_gen.sv
// Four phase-aligned square waves (f..8f) plus a stepping mux select, single-pass or continuous.
module square_wave_gen
    import sqgen_pkg::*;
#(
    parameter int unsigned PRESCALE = SQGEN_PRESCALE,
    parameter int unsigned DWELL    = SQGEN_DWELL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    output logic [3:0] D,
    output logic [1:0] sel,
    output logic       tick,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   DW    = cnt_width(DWELL);
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    sqgen_state_t  state;
    logic [3:0]    wcnt;
    logic [DW-1:0] dcnt;
    logic          accept;
    logic          run_en;
    logic          presc_clr;

    assign run_en    = (state == RUN);
    assign accept    = start && !stop && (state != RUN);
    // Stop also clears the prescaler so it reads zero from the first IDLE cycle.
    assign presc_clr = accept || stop;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (run_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // Bit-reversed so the fastest counter bit drives D[3]; wires straight from flops.
    assign D = {wcnt[0], wcnt[1], wcnt[2], wcnt[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
            dcnt  <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (stop) begin
            state <= IDLE;
            wcnt  <= '0;
            dcnt  <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        wcnt  <= '0;
                        dcnt  <= '0;
                        sel   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        wcnt <= wcnt + 4'd1;
                        if (dcnt == DLAST) begin
                            dcnt <= '0;
                            if (sel != 2'b11) begin
                                sel <= sel + 2'd1;
                            end else if (cont) begin
                                sel <= 2'b00;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= '0;
                    dcnt  <= '0;
                    sel   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen with PRESCALE=4, DWELL=16.
module tb_square_wave_gen;

    localparam int unsigned PS = 4;
    localparam int unsigned DL = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       cont  = 1'b0;
    logic [3:0] D;
    logic [1:0] sel;
    logic       tick;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    square_wave_gen #(
        .PRESCALE(PS),
        .DWELL   (DL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .stop (stop),
        .cont (cont),
        .D    (D),
        .sel  (sel),
        .tick (tick),
        .busy (busy),
        .done (done)
    );

    typedef struct {
        logic       mode;
        int         cyc;
        logic [3:0] d;
        logic [1:0] sel;
        logic       tick;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Start a pass in the given mode, then walk cycles 0..last checking table rows and a cycle model.
    task automatic run_table(input logic mode, input int last);
        bit          saw_done;
        logic [3:0]  w;
        cont = mode;
        saw_done = 1'b0;
        start_pulse();
        for (int n = 0; n <= last; n++) begin
            for (int i = 0; i < tbl.size(); i++) begin
                if (tbl[i].mode == mode && tbl[i].cyc == n) begin
                    chk($sformatf("tbl_m%0d_n%0d_D", mode, n), D, tbl[i].d);
                    chk($sformatf("tbl_m%0d_n%0d_sel", mode, n), sel, tbl[i].sel);
                    chk($sformatf("tbl_m%0d_n%0d_tick", mode, n), tick, tbl[i].tick);
                    chk($sformatf("tbl_m%0d_n%0d_busy", mode, n), busy, tbl[i].busy);
                    chk($sformatf("tbl_m%0d_n%0d_done", mode, n), done, tbl[i].done);
                end
            end
            if (mode == 1'b0 && n < 256) begin
                w = 4'((n / PS) % 16);
                chk($sformatf("freq_n%0d", n), D, {w[0], w[1], w[2], w[3]});
                chk($sformatf("selstep_n%0d", n), sel, 2'(n / (PS * DL)));
                chk($sformatf("tickpos_n%0d", n), tick, ((n % PS) == PS - 1) ? 1'b1 : 1'b0);
            end
            if (done) saw_done = 1'b1;
            if (n != last) step();
        end
        if (mode == 1'b1) chk("cont_never_done", saw_done, 1'b0);
    endtask

    // Walk a pass from cycle n0+1 to 256, optionally poking start mid-run.
    task automatic check_pass(input string tag, input int n0, input bit inject);
        for (int n = n0 + 1; n <= 256; n++) begin
            start = (inject && (n == 31 || n == 101 || n == 201)) ? 1'b1 : 1'b0;
            step();
            start = 1'b0;
            if (n == 63)  chk({tag, "_sel63"}, sel, 2'd0);
            if (n == 64)  chk({tag, "_sel64"}, sel, 2'd1);
            if (n == 128) chk({tag, "_sel128"}, sel, 2'd2);
            if (n == 192) chk({tag, "_sel192"}, sel, 2'd3);
            if (n == 255) chk({tag, "_done255"}, {busy, done}, 2'b10);
            if (n == 256) chk({tag, "_done256"}, {busy, done}, 2'b01);
        end
    endtask

    initial begin
        //                 mode cyc  D      sel   tick  busy  done
        tbl.push_back('{1'b0,   0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0,   3, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0,   4, 4'h8, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0,   8, 4'h4, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  12, 4'hC, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  32, 4'h1, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  60, 4'hF, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  63, 4'hF, 2'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  64, 4'h0, 2'd1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 127, 4'hF, 2'd1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 128, 4'h0, 2'd2, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 196, 4'h8, 2'd3, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 255, 4'hF, 2'd3, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 256, 4'h0, 2'd3, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 260, 4'h0, 2'd3, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 255, 4'hF, 2'd3, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 256, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 320, 4'h0, 2'd1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 512, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1020, 4'hF, 2'd3, 1'b0, 1'b1, 1'b0});

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("reset_D", D, 4'h0);
        chk("reset_sel", sel, 2'd0);
        chk("reset_flags", {tick, busy, done}, 3'b000);
        rst_n = 1'b1;
        step();
        chk("idle_flags", {tick, busy, done}, 3'b000);

        // Single pass with frequency model, then hold in DONE
        run_table(1'b0, 260);

        // Restart from DONE with identical timing, start pokes during RUN ignored
        start_pulse();
        chk("restart_busy", {busy, done, D, sel}, {2'b10, 4'h0, 2'd0});
        check_pass("pass2", 0, 1'b1);

        // Start held across entry to DONE: exactly one DONE cycle
        start = 1'b1;
        step();
        chk("held_start_restart", {busy, done, sel}, {2'b10, 2'd0});
        step();
        start = 1'b0;
        chk("held_start_ignored", {busy, done}, 2'b10);
        check_pass("pass3", 1, 1'b0);

        // Continuous mode from DONE
        run_table(1'b1, 1023);

        // Abort from RUN
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_cont", {busy, done, D, sel}, {2'b00, 4'h0, 2'd0});
        cont = 1'b0;
        start_pulse();
        for (int n = 1; n <= 99; n++) step();
        chk("pre_stop_sel", sel, 2'd1);
        chk("pre_stop_D", D, 4'h1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop100_D", D, 4'h0);
        chk("stop100_sel", sel, 2'd0);
        chk("stop100_flags", {tick, busy, done}, 3'b000);

        // Start and stop together stays IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("startstop_1", {busy, done}, 2'b00);
        step();
        chk("startstop_2", {busy, done, D, sel}, {2'b00, 4'h0, 2'd0});
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset mid-RUN
        start_pulse();
        for (int n = 1; n <= 50; n++) step();
        chk("prerst_D", D, 4'h3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_D", D, 4'h0);
        chk("async_rst_sel", sel, 2'd0);
        chk("async_rst_flags", {tick, busy, done}, 3'b000);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {busy, done, D, sel}, {2'b00, 4'h0, 2'd0});
        start_pulse();
        chk("post_rst_start", {busy, D}, {1'b1, 4'h0});
        for (int n = 1; n <= 4; n++) step();
        chk("post_rst_first_rise", D, 4'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
